// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA test-pattern generator: pattern modes,
// box direction, 12-bit RGB pixel and the colour-bar lookup.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam int   BAR_W     = 80;
  localparam rgb_t RGB_BLACK = rgb_t'(12'h000);
  localparam rgb_t RGB_WHITE = rgb_t'(12'hFFF);
  localparam rgb_t RGB_BOXBG = rgb_t'(12'h008);

  // Eight-entry bar table, left to right across the visible line.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = rgb_t'(12'hFFF);
      3'd1:    c = rgb_t'(12'hFF0);
      3'd2:    c = rgb_t'(12'h0FF);
      3'd3:    c = rgb_t'(12'h0F0);
      3'd4:    c = rgb_t'(12'hF0F);
      3'd5:    c = rgb_t'(12'hF00);
      3'd6:    c = rgb_t'(12'h00F);
      3'd7:    c = rgb_t'(12'h000);
      default: c = rgb_t'(12'h000);
    endcase
    return c;
  endfunction

  // Column to bar number using threshold compares instead of a divider.
  function automatic logic [2:0] bar_index(input logic [15:0] col);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (col >= 16'(i * BAR_W)) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// One axis of the bouncing box: moves STEP per tick between 0 and LIM,
// clamping at either end and reversing direction there.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int LIM   = 608,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [WIDTH-1:0] pos,
  output logic             dir
);

  localparam logic [WIDTH-1:0] LIM_V  = WIDTH'(LIM);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  dir_e             state_r;
  dir_e             state_s;
  logic [WIDTH-1:0] pos_r;
  logic [WIDTH-1:0] pos_s;
  logic [WIDTH-1:0] inc_s;

  // Position and direction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIR_INC;
      pos_r   <= '0;
    end else begin
      state_r <= state_s;
      pos_r   <= pos_s;
    end
  end

  // Next position/direction, evaluated only on a tick.
  always_comb begin
    state_s = state_r;
    pos_s   = pos_r;
    inc_s   = pos_r + STEP_V;
    if (tick) begin
      case (state_r)
        DIR_INC: begin
          if (inc_s >= LIM_V) begin
            pos_s   = LIM_V;
            state_s = DIR_DEC;
          end else begin
            pos_s   = inc_s;
            state_s = DIR_INC;
          end
        end
        DIR_DEC: begin
          if (pos_r <= STEP_V) begin
            pos_s   = '0;
            state_s = DIR_INC;
          end else begin
            pos_s   = pos_r - STEP_V;
            state_s = DIR_DEC;
          end
        end
        default: begin
          pos_s   = '0;
          state_s = DIR_INC;
        end
      endcase
    end else begin
      state_s = state_r;
      pos_s   = pos_r;
    end
  end

  assign pos = pos_r;
  assign dir = state_r;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: bars, checker, gradient or bouncing box, with
// sync/blank delayed through the same two-stage pipeline as the colour.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int HVIS     = 640,
  parameter int VVIS     = 480,
  parameter int BOX      = 32,
  parameter int STEP     = 2,
  parameter int SYNC_POL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] hdata,
  input  logic [WIDTH-1:0] vdata,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             blank_in,
  input  logic [1:0]       mode,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic [3:0]       r,
  output logic [3:0]       g,
  output logic [3:0]       b,
  output logic [7:0]       frame
);

  localparam logic SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  logic             fb_s;
  mode_e            mode_q_r;
  logic [7:0]       frame_r;
  logic [WIDTH-1:0] box_x_s;
  logic [WIDTH-1:0] box_y_s;
  logic             xdir_unused_s;
  logic             ydir_unused_s;
  logic [WIDTH:0]   box_xe_s;
  logic [WIDTH:0]   box_ye_s;
  logic             in_box_s;

  logic [WIDTH-1:0] h1_r;
  logic [WIDTH-1:0] v1_r;
  logic             hs1_r;
  logic             vs1_r;
  logic             bl1_r;

  rgb_t             rgb_s;
  rgb_t             rgb_r;
  logic             hs2_r;
  logic             vs2_r;
  logic             bl2_r;
  logic [7:0]       frame2_r;

  assign fb_s = (vdata == WIDTH'(VVIS)) && (hdata == '0);

  // Frame-boundary state: pattern mode and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q_r <= MODE_BARS;
      frame_r  <= 8'd0;
    end else if (fb_s) begin
      mode_q_r <= mode_e'(mode);
      frame_r  <= frame_r + 8'd1;
    end
  end

  vga_box_mover #(.WIDTH(WIDTH), .LIM(HVIS - BOX), .STEP(STEP)) u_box_x (
    .clk  (clk),
    .rst  (rst),
    .tick (fb_s),
    .pos  (box_x_s),
    .dir  (xdir_unused_s)
  );

  vga_box_mover #(.WIDTH(WIDTH), .LIM(VVIS - BOX), .STEP(STEP)) u_box_y (
    .clk  (clk),
    .rst  (rst),
    .tick (fb_s),
    .pos  (box_y_s),
    .dir  (ydir_unused_s)
  );

  // Stage 1: capture the timing-generator inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_r  <= '0;
      v1_r  <= '0;
      hs1_r <= SYNC_IDLE;
      vs1_r <= SYNC_IDLE;
      bl1_r <= 1'b1;
    end else begin
      h1_r  <= hdata;
      v1_r  <= vdata;
      hs1_r <= hsync_in;
      vs1_r <= vsync_in;
      bl1_r <= blank_in;
    end
  end

  // One extra bit on the far edges so the compare cannot wrap.
  assign box_xe_s = {1'b0, box_x_s} + (WIDTH+1)'(BOX);
  assign box_ye_s = {1'b0, box_y_s} + (WIDTH+1)'(BOX);
  assign in_box_s = (h1_r >= box_x_s) && ({1'b0, h1_r} < box_xe_s) &&
                    (v1_r >= box_y_s) && ({1'b0, v1_r} < box_ye_s);

  // Pattern colour from the stage-1 pixel and the current frame state.
  always_comb begin
    rgb_s = RGB_BLACK;
    if (bl1_r) begin
      rgb_s = RGB_BLACK;
    end else begin
      case (mode_q_r)
        MODE_BARS:  rgb_s = bar_colour(bar_index(16'(h1_r)));
        MODE_CHECK: rgb_s = (h1_r[5] ^ v1_r[5]) ? RGB_WHITE : RGB_BLACK;
        MODE_GRAD:  rgb_s = '{r: h1_r[9:6], g: v1_r[8:5], b: frame_r[3:0]};
        MODE_BOX:   rgb_s = in_box_s ? RGB_WHITE : RGB_BOXBG;
        default:    rgb_s = RGB_BLACK;
      endcase
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r    <= RGB_BLACK;
      hs2_r    <= SYNC_IDLE;
      vs2_r    <= SYNC_IDLE;
      bl2_r    <= 1'b1;
      frame2_r <= 8'd0;
    end else begin
      rgb_r    <= rgb_s;
      hs2_r    <= hs1_r;
      vs2_r    <= vs1_r;
      bl2_r    <= bl1_r;
      frame2_r <= frame_r;
    end
  end

  assign r     = rgb_r.r;
  assign g     = rgb_r.g;
  assign b     = rgb_r.b;
  assign hsync = hs2_r;
  assign vsync = vs2_r;
  assign blank = bl2_r;
  assign frame = frame2_r;

endmodule
